// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue behind it.
// Optional WRARB_FWD_EN adds forwarding of queued results to the two decode read ports.
module regfile_wr_arbiter #(
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_waddr,
    input  logic [31:0] mc_wdata,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_addr,
    input  logic [4:0]  rd1_addr,
    input  logic [4:0]  rd2_addr,
    output logic        hazard1,
    output logic        hazard2,
    output logic        stall_req,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
`ifdef WRARB_FWD_EN
    ,
    output logic        fwd1_valid,
    output logic [31:0] fwd1_data,
    output logic        fwd2_valid,
    output logic [31:0] fwd2_data
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [4:0]    qAddr_q [QDEPTH];
    logic [31:0]   qData_q [QDEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          stallReq_q, stallReq_d;
    logic [31:0]   pending_q, pending_d;

    logic qEmpty, qFull, pipeReq, headGrant, push;
    logic [4:0]  headAddr;
    logic [31:0] headData;
    logic fwd1Hit, fwd2Hit;
    logic [31:0] fwd1Data, fwd2Data;

    assign qEmpty    = (count_q == '0);
    assign qFull     = (count_q == CW'(QDEPTH));
    assign mc_ready  = !rst && !qFull;
    assign pipeReq   = pipe_we && (pipe_waddr != 5'd0);
    assign headGrant = !rst && !pipeReq && !qEmpty;
    // r0 results complete the handshake but never occupy a slot
    assign push      = mc_valid && mc_ready && (mc_waddr != 5'd0);
    assign headAddr  = qAddr_q[rdPtr_q];
    assign headData  = qData_q[rdPtr_q];
    assign stall_req = stallReq_q;

    always_comb begin
        we    = 1'b0;
        waddr = 5'd0;
        wdata = 32'd0;
        if (!rst) begin
            if (pipeReq) begin
                we    = 1'b1;
                waddr = pipe_waddr;
                wdata = pipe_wdata;
            end else if (!qEmpty) begin
                we    = 1'b1;
                waddr = headAddr;
                wdata = headData;
            end
        end
    end

    always_comb begin
        wrPtr_d    = push ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d    = headGrant ? rdPtr_q + PW'(1) : rdPtr_q;
        count_d    = count_q + CW'(push) - CW'(headGrant);
        starve_d   = starve_q;
        stallReq_d = stallReq_q;
        if (headGrant) begin
            starve_d   = 4'd0;
            stallReq_d = 1'b0;
        end else if (!qEmpty) begin
            if (starve_q < 4'(STARVE_MAX)) begin
                starve_d = starve_q + 4'd1;
            end
            stallReq_d = (starve_d >= 4'(STARVE_MAX));
        end
        // A new issue overrides a retiring write to the same register
        pending_d = pending_q;
        if (headGrant) begin
            pending_d[headAddr] = 1'b0;
        end
        if (mc_issue && (mc_issue_addr != 5'd0)) begin
            pending_d[mc_issue_addr] = 1'b1;
        end
    end

    always_comb begin
        fwd1Hit  = 1'b0;
        fwd2Hit  = 1'b0;
        fwd1Data = 32'd0;
        fwd2Data = 32'd0;
        // Scan oldest to youngest so the last match is the youngest
        for (int i = 0; i < QDEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((rd1_addr != 5'd0) && (qAddr_q[rdPtr_q + PW'(i)] == rd1_addr)) begin
                    fwd1Hit  = 1'b1;
                    fwd1Data = qData_q[rdPtr_q + PW'(i)];
                end
                if ((rd2_addr != 5'd0) && (qAddr_q[rdPtr_q + PW'(i)] == rd2_addr)) begin
                    fwd2Hit  = 1'b1;
                    fwd2Data = qData_q[rdPtr_q + PW'(i)];
                end
            end
        end
    end

`ifdef WRARB_FWD_EN
    assign fwd1_valid = fwd1Hit;
    assign fwd1_data  = fwd1Data;
    assign fwd2_valid = fwd2Hit;
    assign fwd2_data  = fwd2Data;
    assign hazard1    = pending_q[rd1_addr] && (rd1_addr != 5'd0) && !fwd1Hit;
    assign hazard2    = pending_q[rd2_addr] && (rd2_addr != 5'd0) && !fwd2Hit;
`else
    logic unusedFwd;
    assign unusedFwd = fwd1Hit ^ fwd2Hit ^ (^fwd1Data) ^ (^fwd2Data);
    assign hazard1   = pending_q[rd1_addr] && (rd1_addr != 5'd0);
    assign hazard2   = pending_q[rd2_addr] && (rd2_addr != 5'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            starve_q   <= 4'd0;
            stallReq_q <= 1'b0;
            pending_q  <= 32'd0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stallReq_q <= stallReq_d;
            pending_q  <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qAddr_q[wrPtr_q] <= mc_waddr;
            qData_q[wrPtr_q] <= mc_wdata;
        end
    end

endmodule
